// File: rtl/hazard_fwd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
// Shared definitions for the hazard/forwarding controller and the EX-stage
// operand forwarding muxes.
//   - FSEL_* : 2-bit forwarding select encoding used on rs_fsel/rt_fsel.
//   - md_state_e : multiply/divide occupancy FSM state encoding.
//   - fsel_t : 2-bit select type.
// ---------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

  typedef logic [1:0] fsel_t;

  localparam fsel_t FSEL_REG   = 2'd0;
  localparam fsel_t FSEL_EXMEM = 2'd1;
  localparam fsel_t FSEL_PC4   = 2'd2;
  localparam fsel_t FSEL_WB    = 2'd3;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_calc.sv
// ---------------------------------------------------------------------------
// fwd_sel_calc
// Combinational forwarding-select and load-use detection for one source
// operand of the instruction in ID.
// Ports:
//   id_reg         in  5  source register number of the ID instruction
//   id_uses        in  1  ID instruction actually reads this operand
//   idex_rd        in  5  destination of the ID/EX instruction
//   idex_regwrite  in  1  ID/EX instruction writes a register
//   idex_memread   in  1  ID/EX instruction is a load
//   idex_link      in  1  ID/EX instruction is JAL/JALR (writes PC+4)
//   exmem_rd       in  5  destination of the EX/MEM instruction
//   exmem_regwrite in  1  EX/MEM instruction writes a register
//   next_sel       out 2  select this operand needs once it reaches EX
//   load_use       out 1  operand depends on a load still in ID/EX
// ---------------------------------------------------------------------------
module fwd_sel_calc
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [4:0] id_reg,
  input  logic       id_uses,
  input  logic [4:0] idex_rd,
  input  logic       idex_regwrite,
  input  logic       idex_memread,
  input  logic       idex_link,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  output fsel_t      next_sel,
  output logic       load_use
);

  // Register $0 is hardwired to zero, so it never forwards. When the operand
  // matches both in-flight producers, the ID/EX one is younger and wins; by
  // the time this instruction is in EX that producer sits in EX/MEM, and the
  // older EX/MEM producer will have moved on to WB.
  always_comb begin
    next_sel = FSEL_REG;
    load_use = 1'b0;
    if (id_uses && (id_reg != 5'd0)) begin
      if ((id_reg == idex_rd) && idex_regwrite) begin
        if (idex_memread) begin
          load_use = 1'b1;
        end else if (idex_link) begin
          next_sel = FSEL_PC4;
        end else begin
          next_sel = FSEL_EXMEM;
        end
      end else if ((id_reg == exmem_rd) && exmem_regwrite) begin
        next_sel = FSEL_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage MIPS pipeline. Computes
// registered forwarding selects for the instruction entering EX, detects
// load-use and multiply/divide-busy hazards, and drives the IF/ID stall and
// ID/EX bubble.
// Configuration macro: HAZ_MD_STALL_EN
//   defined   : multi-cycle MD occupancy FSM/counter and MD-hazard stall.
//   undefined : MD unit treated as single-cycle, md_busy tied low.
// Parameters:
//   MULT_CYCLES  EX occupancy of MULT/MULTU (>=1)
//   DIV_CYCLES   EX occupancy of DIV/DIVU (>=1)
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_rs, id_rt                 ID source registers
//   id_uses_rs, id_uses_rt       ID instruction reads rs / rt
//   id_is_mfhilo                 ID instruction is MFHI/MFLO/MTHI/MTLO
//   id_md_start, id_md_is_div    ID instruction is MULT*/DIV* (1 = divide)
//   idex_rd, idex_regwrite,
//   idex_memread, idex_link      ID/EX producer information
//   exmem_rd, exmem_regwrite     EX/MEM producer information
//   stall_if_id, bubble_id_ex    hold PC+IF/ID, insert NOP into ID/EX
//   rs_fsel, rt_fsel             registered EX forwarding selects
//   md_busy                      multiply/divide unit occupied
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_mfhilo,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic [4:0] idex_rd,
  input  logic       idex_regwrite,
  input  logic       idex_memread,
  input  logic       idex_link,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output fsel_t      rs_fsel,
  output fsel_t      rt_fsel,
  output logic       md_busy
);

  fsel_t rs_next;
  fsel_t rt_next;
  logic  rs_load_use;
  logic  rt_load_use;
  logic  md_hazard;
  logic  stall;

  fwd_sel_calc u_rs_calc (
    .id_reg         (id_rs),
    .id_uses        (id_uses_rs),
    .idex_rd        (idex_rd),
    .idex_regwrite  (idex_regwrite),
    .idex_memread   (idex_memread),
    .idex_link      (idex_link),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .next_sel       (rs_next),
    .load_use       (rs_load_use)
  );

  fwd_sel_calc u_rt_calc (
    .id_reg         (id_rt),
    .id_uses        (id_uses_rt),
    .idex_rd        (idex_rd),
    .idex_regwrite  (idex_regwrite),
    .idex_memread   (idex_memread),
    .idex_link      (idex_link),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .next_sel       (rt_next),
    .load_use       (rt_load_use)
  );

`ifdef HAZ_MD_STALL_EN
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // MD occupancy state and remaining-cycle counter. Reset aborts any
  // operation in flight so the pipeline never stalls on a stale MD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // An MD is accepted only when the ID instruction actually advances, so a
  // start held in ID behind any stall does not load the counter early. The
  // counter holds CYCLES-1 on the first busy cycle and leaves MD_RUN after
  // the cycle in which it reads zero, giving exactly CYCLES busy cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (id_md_start && !stall) begin
          state_d = MD_RUN;
          cnt_d   = id_md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end
      MD_RUN: begin
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy   = (state_q == MD_RUN);
  assign md_hazard = md_busy & (id_is_mfhilo | id_md_start);
`else
  logic md_unused;

  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
  assign md_unused = ^{id_is_mfhilo, id_md_start, id_md_is_div,
                       1'(MULT_CYCLES), 1'(DIV_CYCLES)};
`endif

  assign stall        = rs_load_use | rt_load_use | md_hazard;
  assign stall_if_id  = stall;
  assign bubble_id_ex = stall;

  // Selects travel with the instruction into EX. A stalled cycle sends a
  // bubble into ID/EX, which reads no operands, so its selects are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_fsel <= FSEL_REG;
      rt_fsel <= FSEL_REG;
    end else if (stall) begin
      rs_fsel <= FSEL_REG;
      rt_fsel <= FSEL_REG;
    end else begin
      rs_fsel <= rs_next;
      rt_fsel <= rt_next;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Self-checking bench for hazard_fwd_ctrl: a vector table for the
// forwarding/load-use cases plus hand-written MD occupancy and reset
// sequences. Expected selects go into a queue when a cycle is driven and
// are compared after the following clock edge.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int MULT_CYC = 4;
  localparam int DIV_CYC  = 32;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_mfhilo;
  logic       id_md_start;
  logic       id_md_is_div;
  logic [4:0] idex_rd;
  logic       idex_regwrite;
  logic       idex_memread;
  logic       idex_link;
  logic [4:0] exmem_rd;
  logic       exmem_regwrite;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic [1:0] rs_fsel;
  logic [1:0] rt_fsel;
  logic       md_busy;

  int checks;
  int failures;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] idex_rd;
    logic       idex_rw;
    logic       idex_mr;
    logic       idex_link;
    logic [4:0] exmem_rd;
    logic       exmem_rw;
    logic       exp_stall;
    logic [1:0] exp_rs;
    logic [1:0] exp_rt;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  hazard_fwd_ctrl #(
    .MULT_CYCLES (MULT_CYC),
    .DIV_CYCLES  (DIV_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_is_mfhilo   (id_is_mfhilo),
    .id_md_start    (id_md_start),
    .id_md_is_div   (id_md_is_div),
    .idex_rd        (idex_rd),
    .idex_regwrite  (idex_regwrite),
    .idex_memread   (idex_memread),
    .idex_link      (idex_link),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .stall_if_id    (stall_if_id),
    .bubble_id_ex   (bubble_id_ex),
    .rs_fsel        (rs_fsel),
    .rt_fsel        (rt_fsel),
    .md_busy        (md_busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends even if the flow gets stuck.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_mfhilo = 0; id_md_start = 0; id_md_is_div = 0;
    idex_rd = '0; idex_regwrite = 0; idex_memread = 0; idex_link = 0;
    exmem_rd = '0; exmem_regwrite = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    idex_rd = v.idex_rd; idex_regwrite = v.idex_rw; idex_memread = v.idex_mr;
    idex_link = v.idex_link; exmem_rd = v.exmem_rd; exmem_regwrite = v.exmem_rw;
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational outputs, queues the expected selects, crosses one edge
  // and compares the registered selects against the queued expectation.
  task automatic runCycle(input string name, input logic exp_stall,
                          input logic exp_busy, input logic [1:0] exp_rs,
                          input logic [1:0] exp_rt);
    logic [3:0] exp_sel;
    #1;
    checkOutput({name, "_stall"}, {3'b0, stall_if_id}, {3'b0, exp_stall});
    checkOutput({name, "_bubble"}, {3'b0, bubble_id_ex}, {3'b0, exp_stall});
    checkOutput({name, "_busy"}, {3'b0, md_busy}, {3'b0, exp_busy});
    exp_q.push_back({exp_rs, exp_rt});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_queue"}, 4'h0, 4'hf);
    end else begin
      exp_sel = exp_q.pop_front();
      checkOutput({name, "_fsel"}, {rs_fsel, rt_fsel}, exp_sel);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // rs, rt, uses_rs, uses_rt, idex_rd, rw, mr, link, exmem_rd, rw, stall, rs_sel, rt_sel
    vecs[0]  = '{5'd5,  5'd0,  1, 0, 5'd5,  1, 0, 0, 5'd0,  0, 0, 2'd1, 2'd0};
    vecs[1]  = '{5'd0,  5'd31, 0, 1, 5'd31, 1, 0, 1, 5'd0,  0, 0, 2'd0, 2'd2};
    vecs[2]  = '{5'd0,  5'd31, 0, 1, 5'd0,  0, 0, 0, 5'd31, 1, 0, 2'd0, 2'd3};
    vecs[3]  = '{5'd0,  5'd0,  0, 1, 5'd0,  1, 0, 0, 5'd0,  1, 0, 2'd0, 2'd0};
    vecs[4]  = '{5'd7,  5'd0,  1, 0, 5'd7,  1, 0, 0, 5'd7,  1, 0, 2'd1, 2'd0};
    vecs[5]  = '{5'd5,  5'd0,  0, 0, 5'd5,  1, 0, 0, 5'd5,  1, 0, 2'd0, 2'd0};
    vecs[6]  = '{5'd3,  5'd0,  1, 0, 5'd3,  0, 0, 0, 5'd3,  1, 0, 2'd3, 2'd0};
    vecs[7]  = '{5'd8,  5'd9,  1, 1, 5'd8,  1, 1, 0, 5'd9,  1, 1, 2'd0, 2'd0};
    vecs[8]  = '{5'd8,  5'd9,  1, 1, 5'd0,  0, 0, 0, 5'd8,  1, 0, 2'd3, 2'd0};
    vecs[9]  = '{5'd4,  5'd6,  1, 1, 5'd4,  1, 0, 0, 5'd6,  1, 0, 2'd1, 2'd3};
    vecs[10] = '{5'd0,  5'd10, 0, 1, 5'd10, 1, 1, 0, 5'd0,  0, 1, 2'd0, 2'd0};
    vecs[11] = '{5'd12, 5'd12, 1, 1, 5'd12, 1, 0, 1, 5'd12, 1, 0, 2'd2, 2'd2};

    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_fsel", {rs_fsel, rt_fsel}, 4'h0);
    checkOutput("reset_busy", {3'b0, md_busy}, 4'h0);
    checkOutput("reset_stall", {3'b0, stall_if_id}, 4'h0);
    checkOutput("reset_bubble", {3'b0, bubble_id_ex}, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      runCycle($sformatf("vec%0d", i), vecs[i].exp_stall, 1'b0,
               vecs[i].exp_rs, vecs[i].exp_rt);
    end

`ifdef HAZ_MD_STALL_EN
    // DIV accepted, dependent MFHI held for the full occupancy; a MULT,
    // a forwardable operand and a coincident load-use all still see one
    // stall with cleared selects.
    clearInputs();
    id_md_start = 1; id_md_is_div = 1;
    runCycle("div_accept", 1'b0, 1'b0, 2'd0, 2'd0);
    for (int k = 1; k <= DIV_CYC; k++) begin
      clearInputs();
      id_is_mfhilo = 1;
      if (k == 2) begin
        id_rs = 5'd5; id_uses_rs = 1; idex_rd = 5'd5; idex_regwrite = 1;
      end
      if (k == 3) begin
        id_rs = 5'd8; id_uses_rs = 1; idex_rd = 5'd8; idex_regwrite = 1;
        idex_memread = 1;
      end
      if (k == 5) begin
        id_is_mfhilo = 0; id_md_start = 1; id_md_is_div = 0;
      end
      runCycle($sformatf("div_busy%0d", k), 1'b1, 1'b1, 2'd0, 2'd0);
    end
    clearInputs();
    id_is_mfhilo = 1;
    runCycle("div_done", 1'b0, 1'b0, 2'd0, 2'd0);

    // MULT occupancy, then reset while it is still running.
    clearInputs();
    id_md_start = 1;
    runCycle("mult_accept", 1'b0, 1'b0, 2'd0, 2'd0);
    for (int k = 1; k <= MULT_CYC; k++) begin
      clearInputs();
      id_is_mfhilo = 1;
      runCycle($sformatf("mult_busy%0d", k), 1'b1, 1'b1, 2'd0, 2'd0);
    end
    clearInputs();
    id_is_mfhilo = 1;
    runCycle("mult_done", 1'b0, 1'b0, 2'd0, 2'd0);

    clearInputs();
    id_md_start = 1;
    runCycle("rst_accept", 1'b0, 1'b0, 2'd0, 2'd0);
    clearInputs();
    id_is_mfhilo = 1;
    runCycle("rst_busy", 1'b1, 1'b1, 2'd0, 2'd0);
    rst = 1'b1;
    id_rs = 5'd5; id_uses_rs = 1; idex_rd = 5'd5; idex_regwrite = 1;
    runCycle("rst_edge", 1'b1, 1'b1, 2'd0, 2'd0);
    rst = 1'b0;
    clearInputs();
    id_is_mfhilo = 1;
    runCycle("rst_after", 1'b0, 1'b0, 2'd0, 2'd0);
`else
    // Single-cycle MD unit: MULT then MFLO never stalls, busy stays low.
    clearInputs();
    id_md_start = 1;
    runCycle("mult_nostall", 1'b0, 1'b0, 2'd0, 2'd0);
    for (int k = 1; k <= MULT_CYC + 1; k++) begin
      clearInputs();
      id_is_mfhilo = 1;
      if (k == 2) begin
        id_md_start = 1; id_md_is_div = 1;
      end
      runCycle($sformatf("mflo_nostall%0d", k), 1'b0, 1'b0, 2'd0, 2'd0);
    end
    clearInputs();
    id_md_start = 1; id_md_is_div = 1;
    id_rs = 5'd8; id_uses_rs = 1; idex_rd = 5'd8; idex_regwrite = 1; idex_memread = 1;
    runCycle("loaduse_with_md", 1'b1, 1'b0, 2'd0, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
